// File: rtl/topk_pkg.sv
// -----------------------------------------------------------------------------
// topk_pkg
// Shared types for the top-k sorting network.
//   ctrl_t : per-beat control word carried alongside the data
//            (sign_ctrl: 0 = unsigned key compare, 1 = signed key compare)
//   dir_e  : per-pair sort direction (ASCEND / DESCEND)
//   kv_t   : one key/index lane at the package default widths
//   lo_lane: lane number of the "lo" element of compare pair p
// -----------------------------------------------------------------------------
package topk_pkg;

    localparam int KEY_W = 8;
    localparam int IDX_W = 8;

    typedef struct packed {
        logic [3:0] layer;      // network layer tag, passed through untouched
        logic       sign_ctrl;  // 1 = keys are two's complement
    } ctrl_t;

    typedef enum logic {
        ASCEND  = 1'b0,
        DESCEND = 1'b1
    } dir_e;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [IDX_W-1:0] idx;
    } kv_t;

    // Pairs are numbered by increasing lo lane. Lanes come in blocks of
    // 2*stride: the first half of each block are lo lanes, the second half
    // their hi partners.
    function automatic int lo_lane(input int p, input int stride);
        return (p / stride) * 2 * stride + (p % stride);
    endfunction

endpackage

// File: rtl/cas_kv_cmp.sv
// -----------------------------------------------------------------------------
// cas_kv_cmp
// Combinational compare-and-swap for one key/index pair with stable
// tie-breaking: on equal keys the smaller index goes first in both directions.
//   i_sign            : 1 = signed key compare
//   i_dir             : 0 = ascending, 1 = descending
//   i_lo_key/i_lo_idx : element in the lo lane
//   i_hi_key/i_hi_idx : element in the hi lane
//   o_lo_*/o_hi_*     : ordered pair
//   o_swap            : 1 when the elements were exchanged
// -----------------------------------------------------------------------------
module cas_kv_cmp
    import topk_pkg::*;
#(
    parameter int DATAWIDTH = KEY_W,
    parameter int IDXWIDTH  = IDX_W
) (
    input  logic                 i_sign,
    input  logic                 i_dir,
    input  logic [DATAWIDTH-1:0] i_lo_key,
    input  logic [IDXWIDTH-1:0]  i_lo_idx,
    input  logic [DATAWIDTH-1:0] i_hi_key,
    input  logic [IDXWIDTH-1:0]  i_hi_idx,
    output logic [DATAWIDTH-1:0] o_lo_key,
    output logic [IDXWIDTH-1:0]  o_lo_idx,
    output logic [DATAWIDTH-1:0] o_hi_key,
    output logic [IDXWIDTH-1:0]  o_hi_idx,
    output logic                 o_swap
);

    logic w_key_lt;   // hi key < lo key
    logic w_key_gt;   // hi key > lo key
    logic w_key_eq;
    logic w_idx_lt;   // hi idx < lo idx (tie-break, always ascending)

    assign w_key_lt = i_sign ? ($signed(i_hi_key) < $signed(i_lo_key)) : (i_hi_key < i_lo_key);
    assign w_key_gt = i_sign ? ($signed(i_hi_key) > $signed(i_lo_key)) : (i_hi_key > i_lo_key);
    assign w_key_eq = (i_hi_key == i_lo_key);
    assign w_idx_lt = (i_hi_idx < i_lo_idx);

    // Swap only when hi strictly precedes lo; a full tie keeps the order.
    assign o_swap = ((dir_e'(i_dir) == DESCEND) ? w_key_gt : w_key_lt) | (w_key_eq & w_idx_lt);

    assign o_lo_key = o_swap ? i_hi_key : i_lo_key;
    assign o_lo_idx = o_swap ? i_hi_idx : i_lo_idx;
    assign o_hi_key = o_swap ? i_lo_key : i_hi_key;
    assign o_hi_idx = o_swap ? i_lo_idx : i_hi_idx;

endmodule

// File: rtl/cas_stage.sv
// -----------------------------------------------------------------------------
// cas_stage
// One elastic compare-and-swap layer of the top-k sorting network.
// NUM_LANES key/index lanes are paired at distance STRIDE, each pair is
// ordered by a cas_kv_cmp, and the result is registered behind a
// valid/ready handshake with a one-entry skid buffer.
//   clk_i, rstn_i     : clock, asynchronous active-low reset
//   flush_i           : synchronous flush, drops all held beats
//   valid_i / ready_o : input handshake (ready_o comes straight from a flop)
//   ctrl_i, dir_i     : per-beat control and per-pair direction
//   key_i, idx_i      : packed lanes, lane i at [i*W +: W]
//   valid_o / ready_i : output handshake
//   ctrl_o, key_o,
//   idx_o, swap_o     : registered result and per-pair swap flags
// -----------------------------------------------------------------------------
module cas_stage
    import topk_pkg::*;
#(
    parameter  int DATAWIDTH = 8,
    parameter  int IDXWIDTH  = 8,
    parameter  int NUM_LANES = 8,
    parameter  int STRIDE    = 1,
    localparam int NUM_PAIRS = NUM_LANES / 2
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           flush_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  ctrl_t                          ctrl_i,
    input  logic [NUM_PAIRS-1:0]           dir_i,
    input  logic [NUM_LANES*DATAWIDTH-1:0] key_i,
    input  logic [NUM_LANES*IDXWIDTH-1:0]  idx_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output ctrl_t                          ctrl_o,
    output logic [NUM_LANES*DATAWIDTH-1:0] key_o,
    output logic [NUM_LANES*IDXWIDTH-1:0]  idx_o,
    output logic [NUM_PAIRS-1:0]           swap_o
);

    typedef struct packed {
        ctrl_t                          ctrl;
        logic [NUM_LANES*DATAWIDTH-1:0] key;
        logic [NUM_LANES*IDXWIDTH-1:0]  idx;
        logic [NUM_PAIRS-1:0]           swap;
    } beat_t;

    logic [NUM_LANES*DATAWIDTH-1:0] w_key_sw;
    logic [NUM_LANES*IDXWIDTH-1:0]  w_idx_sw;
    logic [NUM_PAIRS-1:0]           w_swap;
    beat_t                          w_new;
    logic                           w_accept;
    logic                           w_out_free;

    beat_t r_out;
    logic  r_out_valid;
    beat_t r_skid;
    logic  r_skid_valid;

    // Every lane belongs to exactly one pair, so the swapped vectors are
    // fully driven by the comparator instances.
    for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
        localparam int LO = lo_lane(p, STRIDE);
        localparam int HI = LO + STRIDE;

        cas_kv_cmp #(
            .DATAWIDTH (DATAWIDTH),
            .IDXWIDTH  (IDXWIDTH)
        ) u_cmp (
            .i_sign   (ctrl_i.sign_ctrl),
            .i_dir    (dir_i[p]),
            .i_lo_key (key_i[LO*DATAWIDTH +: DATAWIDTH]),
            .i_lo_idx (idx_i[LO*IDXWIDTH  +: IDXWIDTH]),
            .i_hi_key (key_i[HI*DATAWIDTH +: DATAWIDTH]),
            .i_hi_idx (idx_i[HI*IDXWIDTH  +: IDXWIDTH]),
            .o_lo_key (w_key_sw[LO*DATAWIDTH +: DATAWIDTH]),
            .o_lo_idx (w_idx_sw[LO*IDXWIDTH  +: IDXWIDTH]),
            .o_hi_key (w_key_sw[HI*DATAWIDTH +: DATAWIDTH]),
            .o_hi_idx (w_idx_sw[HI*IDXWIDTH  +: IDXWIDTH]),
            .o_swap   (w_swap[p])
        );
    end

    assign w_new      = '{ctrl: ctrl_i, key: w_key_sw, idx: w_idx_sw, swap: w_swap};
    assign w_accept   = valid_i & ~r_skid_valid;
    // The output register may load this cycle: empty, or its beat leaves now.
    assign w_out_free = ~r_out_valid | ready_i;

    // NOTE: state is written with non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush_i) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // ready_o was low, so no input can be accepted this cycle.
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) begin
                    r_out <= w_new;
                end
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
        end
    end

    // NOTE: the skid payload has no reset; it is only ever observed behind
    // r_skid_valid, which is reset.
    always_ff @(posedge clk_i) begin
        if (w_accept && !w_out_free) begin
            r_skid <= w_new;
        end
    end

    assign ready_o = ~r_skid_valid;
    assign valid_o = r_out_valid;
    assign ctrl_o  = r_out.ctrl;
    assign key_o   = r_out.key;
    assign idx_o   = r_out.idx;
    assign swap_o  = r_out.swap;

endmodule

// File: tb/tb_cas_stage.sv
// -----------------------------------------------------------------------------
// tb_cas_stage
// Two cas_stage instances (STRIDE 1 and STRIDE 2) share the input stimulus.
// A reference model pushes expected beats into one queue per instance at
// acceptance; a monitor pops and compares on every output transfer.
// -----------------------------------------------------------------------------
module tb_cas_stage;
    import topk_pkg::*;

    localparam int NL = 8;
    localparam int NP = 4;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [63:0] key;
        logic [63:0] idx;
        logic [3:0]  swap;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        flush_i;
    logic        valid_i;
    logic        ready_i;
    ctrl_t       ctrl_i;
    logic [3:0]  dir_i;
    logic [63:0] key_i;
    logic [63:0] idx_i;

    logic        ready_a, valid_a, ready_b, valid_b;
    ctrl_t       ctrl_a, ctrl_b;
    logic [63:0] key_a, idx_a, key_b, idx_b;
    logic [3:0]  swap_a, swap_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk_i = ~clk_i;

    cas_stage #(.DATAWIDTH(8), .IDXWIDTH(8), .NUM_LANES(NL), .STRIDE(1)) u_dut_s1 (
        .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_a), .ctrl_i(ctrl_i), .dir_i(dir_i),
        .key_i(key_i), .idx_i(idx_i), .valid_o(valid_a), .ready_i(ready_i),
        .ctrl_o(ctrl_a), .key_o(key_a), .idx_o(idx_a), .swap_o(swap_a)
    );

    cas_stage #(.DATAWIDTH(8), .IDXWIDTH(8), .NUM_LANES(NL), .STRIDE(2)) u_dut_s2 (
        .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_b), .ctrl_i(ctrl_i), .dir_i(dir_i),
        .key_i(key_i), .idx_i(idx_i), .valid_o(valid_b), .ready_i(ready_i),
        .ctrl_o(ctrl_b), .key_o(key_b), .idx_o(idx_b), .swap_o(swap_b)
    );

    // Reference model: walk the lanes, every lane whose stride block is even
    // opens the next pair; order by integer value of the keys.
    function automatic exp_t model(input logic [63:0] k, input logic [63:0] ix,
                                   input logic [3:0] d, input ctrl_t c, input int stride);
        exp_t e;
        int   p, lo, hi, kl, kh, il, ih;
        logic hi_first;
        e.ctrl = c; e.key = k; e.idx = ix; e.swap = '0; p = 0;
        for (int i = 0; i < NL; i++) begin
            if (((i / stride) % 2) == 0) begin
                lo = i; hi = i + stride;
                kl = int'(k[lo*8 +: 8]); kh = int'(k[hi*8 +: 8]);
                if (c.sign_ctrl) begin
                    if (kl > 127) kl -= 256;
                    if (kh > 127) kh -= 256;
                end
                il = int'(ix[lo*8 +: 8]); ih = int'(ix[hi*8 +: 8]);
                if (d[p]) hi_first = (kh > kl) || (kh == kl && ih < il);
                else      hi_first = (kh < kl) || (kh == kl && ih < il);
                if (hi_first) begin
                    e.key[lo*8 +: 8] = k[hi*8 +: 8];  e.key[hi*8 +: 8] = k[lo*8 +: 8];
                    e.idx[lo*8 +: 8] = ix[hi*8 +: 8]; e.idx[hi*8 +: 8] = ix[lo*8 +: 8];
                    e.swap[p] = 1'b1;
                end
                p++;
            end
        end
        return e;
    endfunction

    function automatic logic [63:0] pack8(input logic [7:0] v [8]);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = v[i];
        return r;
    endfunction

    function automatic logic [63:0] lane_idx();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(i);
        return r;
    endfunction

    // Scoreboard monitor: one comparison per transferred beat per instance.
    always @(negedge clk_i) begin
        if (rstn_i && ready_i && valid_a) begin
            n_checks++;
            if (q_a.size() == 0) begin
                n_errors++;
                $display("FAIL s1_unexpected_beat got key=%h idx=%h", key_a, idx_a);
            end else begin
                mon_e = q_a.pop_front();
                if ({ctrl_a, key_a, idx_a, swap_a} !== mon_e) begin
                    n_errors++;
                    $display("FAIL s1_beat got ctrl=%h key=%h idx=%h swap=%b exp ctrl=%h key=%h idx=%h swap=%b",
                             ctrl_a, key_a, idx_a, swap_a, mon_e.ctrl, mon_e.key, mon_e.idx, mon_e.swap);
                end
            end
        end
        if (rstn_i && ready_i && valid_b) begin
            n_checks++;
            if (q_b.size() == 0) begin
                n_errors++;
                $display("FAIL s2_unexpected_beat got key=%h idx=%h", key_b, idx_b);
            end else begin
                mon_e = q_b.pop_front();
                if ({ctrl_b, key_b, idx_b, swap_b} !== mon_e) begin
                    n_errors++;
                    $display("FAIL s2_beat got ctrl=%h key=%h idx=%h swap=%b exp ctrl=%h key=%h idx=%h swap=%b",
                             ctrl_b, key_b, idx_b, swap_b, mon_e.ctrl, mon_e.key, mon_e.idx, mon_e.swap);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push_exp();
        q_a.push_back(model(key_i, idx_i, dir_i, ctrl_i, 1));
        q_b.push_back(model(key_i, idx_i, dir_i, ctrl_i, 2));
    endtask

    // Present the current inputs until accepted (bounded); returns just
    // after the accepting edge with valid_i dropped.
    task automatic drive();
        int waited = 0;
        valid_i = 1'b1;
        @(negedge clk_i);
        while (!ready_a && waited < 50) begin
            @(negedge clk_i);
            waited++;
        end
        if (!ready_a) begin
            n_checks++; n_errors++;
            $display("FAIL accept_timeout got ready_o=0 exp ready_o=1");
        end else if (!flush_i) begin
            push_exp();
        end
        tick();
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        ctrl_i = '0; dir_i = '0; key_i = '0; idx_i = '0;
        #12;
        check_val("reset_valid_o", 64'(valid_a), 64'd0);
        check_val("reset_ready_o", 64'(ready_a), 64'd1);
        check_val("reset_key_o",   key_a, 64'd0);
        check_val("reset_idx_o",   idx_a, 64'd0);
        check_val("reset_swap_o",  64'(swap_a), 64'd0);
        check_val("reset_ctrl_o",  64'(ctrl_b), 64'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        tick();
    endtask

    task automatic test_unsigned_asc();
        logic [7:0] ka [8];
        logic [7:0] ke [8];
        logic [7:0] ie [8];
        ka = '{8'd5, 8'd3, 8'd9, 8'd9, 8'd0, 8'd255, 8'd7, 8'd1};
        ke = '{8'd3, 8'd5, 8'd9, 8'd9, 8'd0, 8'd255, 8'd1, 8'd7};
        ie = '{8'd1, 8'd0, 8'd2, 8'd3, 8'd4, 8'd5,   8'd7, 8'd6};
        ready_i = 1'b1;
        ctrl_i = '{layer: 4'h3, sign_ctrl: 1'b0};
        dir_i = 4'b0000;
        key_i = pack8(ka);
        idx_i = lane_idx();
        drive();
        check_val("uasc_valid", 64'(valid_a), 64'd1);
        check_val("uasc_key",   key_a, pack8(ke));
        check_val("uasc_idx",   idx_a, pack8(ie));
        check_val("uasc_swap",  64'(swap_a), 64'b1001);
        check_val("uasc_ctrl",  64'(ctrl_a), 64'h6);
    endtask

    task automatic test_signed_desc();
        ready_i = 1'b1;
        dir_i = 4'b1111;
        key_i = '0;
        key_i[7:0] = 8'hFF;
        key_i[23:16] = 8'h01;
        idx_i = lane_idx();
        ctrl_i = '{layer: 4'h1, sign_ctrl: 1'b1};
        drive();
        check_val("sdesc_lane0", 64'(key_b[7:0]),   64'h01);
        check_val("sdesc_lane2", 64'(key_b[23:16]), 64'hFF);
        check_val("sdesc_swap",  64'(swap_b),       64'b0001);
        ctrl_i = '{layer: 4'h1, sign_ctrl: 1'b0};
        drive();
        check_val("udesc_lane0", 64'(key_b[7:0]), 64'hFF);
        check_val("udesc_swap",  64'(swap_b),     64'b0000);
    endtask

    task automatic test_tie_break();
        ready_i = 1'b1;
        ctrl_i = '{layer: 4'h2, sign_ctrl: 1'b0};
        key_i = '0;
        key_i[7:0] = 8'd7;
        key_i[15:8] = 8'd7;
        idx_i = lane_idx();
        idx_i[7:0] = 8'd9;
        idx_i[15:8] = 8'd2;
        dir_i = 4'b0000;
        drive();
        check_val("tie_asc_swap",  64'(swap_a[0]),   64'd1);
        check_val("tie_asc_idx",   64'(idx_a[7:0]),  64'd2);
        dir_i = 4'b1111;
        drive();
        check_val("tie_desc_swap", 64'(swap_a[0]),   64'd1);
        check_val("tie_desc_idx",  64'(idx_a[15:8]), 64'd9);
        dir_i = 4'b0000;
        idx_i[7:0] = 8'd2;
        idx_i[15:8] = 8'd9;
        drive();
        check_val("tie_order_swap", 64'(swap_a[0]),  64'd0);
        check_val("tie_order_idx",  64'(idx_a[7:0]), 64'd2);
    endtask

    task automatic test_backpressure();
        exp_t ea, eb, ec;
        ctrl_i = '{layer: 4'h5, sign_ctrl: 1'b0};
        dir_i = 4'b0101;
        idx_i = lane_idx();
        ready_i = 1'b1;
        // cycle 0: A presented, output empty
        key_i = 64'h1122_3344_5566_7788;
        valid_i = 1'b1;
        ea = model(key_i, idx_i, dir_i, ctrl_i, 1);
        @(negedge clk_i);
        check_val("bp_ready_a", 64'(ready_a), 64'd1);
        push_exp();
        tick();
        // cycle 1: A on output, downstream stalls, B goes to skid
        ready_i = 1'b0;
        key_i = 64'h0f1e_2d3c_4b5a_6978;
        eb = model(key_i, idx_i, dir_i, ctrl_i, 1);
        @(negedge clk_i);
        check_val("bp_a_appears", key_a, ea.key);
        check_val("bp_ready_b", 64'(ready_a), 64'd1);
        push_exp();
        tick();
        // cycles 2-3: C waits, A held
        key_i = 64'hf0e1_d2c3_b4a5_9687;
        ec = model(key_i, idx_i, dir_i, ctrl_i, 1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            check_val("bp_ready_low", 64'(ready_a), 64'd0);
            check_val("bp_a_held", {valid_a, key_a[62:0]}, {1'b1, ea.key[62:0]});
            check_val("bp_a_held_idx", idx_a, ea.idx);
            tick();
        end
        // cycle 4: release, A transfers
        ready_i = 1'b1;
        @(negedge clk_i);
        check_val("bp_a_out", key_a, ea.key);
        tick();
        // cycle 5: B from skid, ready_o back high, C accepted
        @(negedge clk_i);
        check_val("bp_b_out", key_a, eb.key);
        check_val("bp_ready_up", 64'(ready_a), 64'd1);
        if (ready_a) push_exp();
        tick();
        valid_i = 1'b0;
        // cycle 6: C follows immediately
        @(negedge clk_i);
        check_val("bp_c_out", {63'(key_a[62:0]), valid_a}, {63'(ec.key[62:0]), 1'b1});
        tick();
    endtask

    task automatic test_flush();
        ready_i = 1'b0;
        ctrl_i = '{layer: 4'h7, sign_ctrl: 1'b1};
        dir_i = 4'b1010;
        idx_i = lane_idx();
        key_i = 64'h8001_7f02_fe03_0104;
        drive();
        key_i = 64'h0102_0304_0506_0708;
        drive();
        check_val("flush_pre_ready", 64'(ready_a), 64'd0);
        flush_i = 1'b1;
        valid_i = 1'b1;
        key_i = 64'hdead_beef_cafe_f00d;
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        q_a.delete();
        q_b.delete();
        check_val("flush_valid_o", 64'({valid_a, valid_b}), 64'd0);
        check_val("flush_ready_o", 64'({ready_a, ready_b}), 64'b11);
        ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val("flush_no_beat", 64'(valid_a), 64'd0);
        end
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    for (int l = 0; l < NL; l++) begin
                        key_i[l*8 +: 8] = (n % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
                        idx_i[l*8 +: 8] = 8'($urandom_range(0, 7));
                    end
                    dir_i = 4'($urandom);
                    ctrl_i = ctrl_t'(5'($urandom));
                    drive();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    ready_i = ($urandom_range(0, 3) != 0);
                    tick();
                end
                ready_i = 1'b1;
            end
        join
        for (int c = 0; c < 20 && (q_a.size() != 0 || q_b.size() != 0); c++) tick();
        check_val("random_drain", 64'(q_a.size() + q_b.size()), 64'd0);
    endtask

    task automatic test_async_reset();
        ready_i = 1'b0;
        ctrl_i = '{layer: 4'hf, sign_ctrl: 1'b1};
        dir_i = 4'b1111;
        idx_i = lane_idx();
        key_i = 64'h0102_0304_0506_0708;
        drive();
        key_i = 64'h1111_2222_3333_4444;
        drive();
        #2;
        rstn_i = 1'b0;
        #1;
        check_val("arst_valid_o", 64'({valid_a, valid_b}), 64'd0);
        check_val("arst_key_o",   key_a | key_b, 64'd0);
        check_val("arst_idx_o",   idx_a | idx_b, 64'd0);
        check_val("arst_swap_o",  64'({swap_a, swap_b}), 64'd0);
        check_val("arst_ctrl_o",  64'({ctrl_a, ctrl_b}), 64'd0);
        check_val("arst_ready_o", 64'({ready_a, ready_b}), 64'b11);
        q_a.delete();
        q_b.delete();
        @(negedge clk_i);
        rstn_i = 1'b1;
        ready_i = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        check_val("arst_no_beat", 64'(valid_a), 64'd0);
    endtask

    initial begin
        test_reset();
        test_unsigned_asc();
        test_signed_desc();
        test_tie_break();
        test_backpressure();
        test_flush();
        test_random();
        test_async_reset();
        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
